pulse_shaper_array: RTL and testbench

Parametrised, multi-channel successor to the single-channel 500 MHz pulse shaper in the time-correlation analyser front end. Each detector channel input is synchronised and rising-edge detected, then converted to a clean pulse of programmable width followed by a programmable dead time. Dead time can be non-paralyzable or paralyzable. Per-channel saturating counters record accepted and dead-time-rejected events, which the photon-counting logic uses for dead-time correction.

---
 rtl/pulse_shaper_array.sv | 171 +++++++++++++++++
 tb/tb_pulse_shaper_array.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_shaper_array.sv
// Multi-channel pulse shaper: sync + edge detect, fixed-width pulse, dead time, accept/reject counters.
// Latency: input first sampled high at edge E0 -> pulse/busy high from edge E(SYNC_STAGES).
// Backpressure: none; edges arriving while a channel is busy are counted as rejects and otherwise dropped.
module pulse_shaper_array #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EVT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         channel,
    input  logic [N_CH-1:0]         enable,
    input  logic [CNT_W-1:0]        pulse_width,
    input  logic [CNT_W-1:0]        dead_time,
    input  logic                    paralyzable,
    input  logic                    cnt_clear,
    output logic [N_CH-1:0]         pulse,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH*EVT_W-1:0]   accept_cnt,
    output logic [N_CH*EVT_W-1:0]   reject_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0] EVT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};

    // Effective timing shared by all channels: width at least 1, dead window never shorter than the pulse.
    logic [CNT_W-1:0] pw_eff;
    logic [CNT_W-1:0] dt_eff;

    assign pw_eff = (pulse_width == '0) ? CNT_ONE : pulse_width;
    assign dt_eff = (dead_time < pw_eff) ? pw_eff : dead_time;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   hist_q;
        logic                   edge_det;
        logic                   hit;
        logic                   restart;

        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       pw_cnt_q, pw_cnt_d;
        logic [CNT_W-1:0]       dt_cnt_q, dt_cnt_d;
        logic [CNT_W-1:0]       pw_lat_q, pw_lat_d;
        logic [CNT_W-1:0]       dt_lat_q, dt_lat_d;
        logic                   par_lat_q, par_lat_d;
        logic                   pulse_q, pulse_d;
        logic                   busy_q, busy_d;
        logic                   acc_inc;
        logic                   rej_inc;
        logic [EVT_W-1:0]       acc_q, acc_d;
        logic [EVT_W-1:0]       rej_q, rej_d;

        // Synchroniser chain plus one-cycle history of the synchronised level for rising-edge detect.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
                hist_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], channel[i]};
                hist_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
        assign hit      = edge_det & enable[i];
        assign restart  = hit & par_lat_q;

        // Next-state logic: dt_cnt counts cycles since the (possibly restarted) window start, pw_cnt since pulse rise.
        always_comb begin
            state_d   = state_q;
            pw_cnt_d  = pw_cnt_q;
            dt_cnt_d  = dt_cnt_q;
            pw_lat_d  = pw_lat_q;
            dt_lat_d  = dt_lat_q;
            par_lat_d = par_lat_q;
            acc_inc   = 1'b0;
            rej_inc   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_d   = PULSE;
                        pw_cnt_d  = CNT_ONE;
                        dt_cnt_d  = CNT_ONE;
                        pw_lat_d  = pw_eff;
                        dt_lat_d  = dt_eff;
                        par_lat_d = paralyzable;
                        acc_inc   = 1'b1;
                    end
                end
                PULSE, DEAD: begin
                    rej_inc = hit;
                    if (!restart && (dt_cnt_q == dt_lat_q)) begin
                        state_d = IDLE;
                    end else begin
                        dt_cnt_d = restart ? CNT_ONE : (dt_cnt_q + CNT_ONE);
                        if (state_q == PULSE) begin
                            if (pw_cnt_q == pw_lat_q) begin
                                state_d = DEAD;
                            end else begin
                                pw_cnt_d = pw_cnt_q + CNT_ONE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            pulse_d = (state_d == PULSE);
            busy_d  = (state_d != IDLE);
        end

        // FSM, timers, latched parameters and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= IDLE;
                pw_cnt_q  <= '0;
                dt_cnt_q  <= '0;
                pw_lat_q  <= '0;
                dt_lat_q  <= '0;
                par_lat_q <= 1'b0;
                pulse_q   <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                pw_cnt_q  <= pw_cnt_d;
                dt_cnt_q  <= dt_cnt_d;
                pw_lat_q  <= pw_lat_d;
                dt_lat_q  <= dt_lat_d;
                par_lat_q <= par_lat_d;
                pulse_q   <= pulse_d;
                busy_q    <= busy_d;
            end
        end

        // Saturating event counters; a clear in the same cycle as an event discards the event.
        always_comb begin
            acc_d = acc_q;
            rej_d = rej_q;
            if (cnt_clear) begin
                acc_d = '0;
                rej_d = '0;
            end else begin
                if (acc_inc && (acc_q != {EVT_W{1'b1}})) acc_d = acc_q + EVT_ONE;
                if (rej_inc && (rej_q != {EVT_W{1'b1}})) rej_d = rej_q + EVT_ONE;
            end
        end

        // Counter registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
                rej_q <= '0;
            end else begin
                acc_q <= acc_d;
                rej_q <= rej_d;
            end
        end

        assign pulse[i]                     = pulse_q;
        assign busy[i]                      = busy_q;
        assign accept_cnt[i*EVT_W +: EVT_W] = acc_q;
        assign reject_cnt[i*EVT_W +: EVT_W] = rej_q;
    end

endmodule

// File: tb/tb_pulse_shaper_array.sv
module tb_pulse_shaper_array;
    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int EVT_W = 32;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       channel;
    logic [N_CH-1:0]       enable;
    logic [CNT_W-1:0]      pulse_width;
    logic [CNT_W-1:0]      dead_time;
    logic                  paralyzable;
    logic                  cnt_clear;
    logic [N_CH-1:0]       pulse;
    logic [N_CH-1:0]       busy;
    logic [N_CH*EVT_W-1:0] accept_cnt;
    logic [N_CH*EVT_W-1:0] reject_cnt;

    pulse_shaper_array #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .EVT_W(EVT_W)) dut (
        .clk(clk), .rst(rst), .channel(channel), .enable(enable),
        .pulse_width(pulse_width), .dead_time(dead_time), .paralyzable(paralyzable),
        .cnt_clear(cnt_clear), .pulse(pulse), .busy(busy),
        .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard of expected busy episodes: rise cycle, pulse cycles, busy cycles.
    typedef struct {
        int ch;
        int rise;
        int pw;
        int bw;
    } exp_t;
    exp_t sbq[$];

    longint exp_acc[N_CH];
    longint exp_rej[N_CH];

    function automatic longint sat(input longint a);
        return (a > CMAX) ? CMAX : a;
    endfunction

    task automatic push_exp(input int ch, input int rise, input int pw, input int bw);
        exp_t e;
        e.ch = ch; e.rise = rise; e.pw = pw; e.bw = bw;
        sbq.push_back(e);
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < N_CH; i++) begin
            chk($sformatf("%s_acc%0d", tag, i), 64'(accept_cnt[i*EVT_W +: EVT_W]), exp_acc[i]);
            chk($sformatf("%s_rej%0d", tag, i), 64'(reject_cnt[i*EVT_W +: EVT_W]), exp_rej[i]);
        end
    endtask

    // Monitor: measure each busy episode and compare it with the oldest expectation for that channel.
    logic [N_CH-1:0] busy_prev = '0;
    int start_c[N_CH];
    int pcnt[N_CH];
    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (busy[i] && !busy_prev[i]) begin
                start_c[i] = cyc;
                pcnt[i]    = 0;
            end
            if (busy[i] && pulse[i]) pcnt[i]++;
            if (!busy[i] && busy_prev[i]) begin
                int idx;
                idx = -1;
                for (int q = 0; q < sbq.size(); q++)
                    if (idx < 0 && sbq[q].ch == i) idx = q;
                if (idx < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event ch%0d rise=%0d actual=present expected=none", i, start_c[i]);
                end else begin
                    chk($sformatf("ch%0d_rise", i), 64'(start_c[i]), 64'(sbq[idx].rise));
                    chk($sformatf("ch%0d_pulse_width", i), 64'(pcnt[i]), 64'(sbq[idx].pw));
                    chk($sformatf("ch%0d_busy_width", i), 64'(cyc - start_c[i]), 64'(sbq[idx].bw));
                    sbq.delete(idx);
                end
            end
        end
        busy_prev = busy;
    end

    // Stimulus vectors: drive offsets d*, expected rise offsets r* (-1 = none), relative to the start cycle.
    typedef struct {
        int ch; int pw; int dt; int par;
        int d0; int d1; int d2;
        int r0; int r1; int r2;
        int epw; int ebw; int acc; int rej; int len;
    } vec_t;
    vec_t vecs[9];

    task automatic run_vec(input int id, input vec_t v);
        int c0;
        int d[3];
        int r[3];
        c0 = cyc;
        d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
        r[0] = v.r0; r[1] = v.r1; r[2] = v.r2;
        pulse_width = CNT_W'(v.pw);
        dead_time   = CNT_W'(v.dt);
        paralyzable = v.par[0];
        for (int j = 0; j < 3; j++)
            if (r[j] >= 0) push_exp(v.ch, c0 + r[j], v.epw, v.ebw);
        for (int k = 0; k < v.len; k++) begin
            for (int j = 0; j < 3; j++) begin
                if (d[j] >= 0 && k == d[j] + 3) channel[v.ch] = 1'b0;
                if (d[j] == k) channel[v.ch] = 1'b1;
            end
            @(negedge clk);
        end
        exp_acc[v.ch] = sat(exp_acc[v.ch] + v.acc);
        exp_rej[v.ch] = sat(exp_rej[v.ch] + v.rej);
        check_counters($sformatf("vec%0d", id));
    endtask

    initial begin
        int c0;
        //           ch pw  dt par  d0  d1  d2  r0  r1  r2 epw ebw acc rej len
        vecs[0] = '{0, 1, 30, 0,  0, -1, -1,  3, -1, -1,  1, 30,  1,  0, 40};
        vecs[1] = '{1, 4, 20, 0,  0, 10, 25,  3, 28, -1,  4, 20,  2,  1, 55};
        vecs[2] = '{2, 2, 10, 1,  0,  8, 16,  3, -1, -1,  2, 26,  1,  2, 40};
        vecs[3] = '{0, 5,  0, 0,  0,  6, -1,  3,  9, -1,  5,  5,  2,  0, 25};
        vecs[4] = '{0, 5,  0, 0,  0,  5, -1,  3, -1, -1,  5,  5,  1,  1, 20};
        vecs[5] = '{3, 0,  3, 0,  0, -1, -1,  3, -1, -1,  1,  3,  1,  0, 12};
        vecs[6] = '{1, 6,  2, 0,  0, -1, -1,  3, -1, -1,  6,  6,  1,  0, 15};
        vecs[7] = '{3, 6,  6, 1,  0,  4, -1,  3, -1, -1,  6, 10,  1,  1, 20};
        vecs[8] = '{3, 2,  4, 0,  0,  8, 16,  3, 11, 19,  2,  4,  3,  0, 28};

        for (int i = 0; i < N_CH; i++) begin
            exp_acc[i] = 0;
            exp_rej[i] = 0;
        end
        rst = 1'b1; channel = '0; enable = '1; cnt_clear = 1'b0;
        pulse_width = 8'd1; dead_time = 8'd30; paralyzable = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_pulse", 64'(pulse), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        check_counters("reset");
        rst = 1'b0;

        for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

        // Simultaneous edges on all channels, only ch1/ch3 armed; disarm and change timing mid-pulse.
        c0 = cyc;
        pulse_width = 8'd4; dead_time = 8'd6; paralyzable = 1'b0;
        enable = 4'b1010;
        push_exp(1, c0 + 3, 4, 6);
        push_exp(3, c0 + 3, 4, 6);
        channel = '1;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) channel = '0;
            if (k == 4) begin
                enable = '0;
                pulse_width = 8'd1;
                dead_time = 8'd1;
            end
            if (k == 6) chk("multi_pulse_last_cycle", 64'(pulse), 64'b1010);
            @(negedge clk);
        end
        enable = '1;
        exp_acc[1]++;
        exp_acc[3]++;
        check_counters("multi");

        // Saturation: preload ch3 accept counter just below full scale.
        force dut.g_ch[3].acc_q = 32'hFFFF_FFFE;
        #1;
        release dut.g_ch[3].acc_q;
        exp_acc[3] = 64'hFFFF_FFFE;
        chk("preload_acc3", 64'(accept_cnt[3*EVT_W +: EVT_W]), exp_acc[3]);
        run_vec(8, vecs[8]);

        // Clear coincident with an accepted edge: clear wins, pulse still issued.
        c0 = cyc;
        pulse_width = 8'd3; dead_time = 8'd3;
        push_exp(0, c0 + 3, 3, 3);
        for (int k = 0; k < 10; k++) begin
            if (k == 0) channel[0] = 1'b1;
            if (k == 2) cnt_clear = 1'b1;
            if (k == 3) begin
                cnt_clear = 1'b0;
                channel[0] = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < N_CH; i++) begin
            exp_acc[i] = 0;
            exp_rej[i] = 0;
        end
        check_counters("clear");

        // Reset asserted mid-pulse drops the pulse on the next edge.
        c0 = cyc;
        pulse_width = 8'd5; dead_time = 8'd8;
        push_exp(2, c0 + 3, 2, 2);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) channel[2] = 1'b1;
            if (k == 3) channel[2] = 1'b0;
            if (k == 4) rst = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid_pulse", 64'(pulse), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        check_counters("rst_mid");

        // Input held high across reset release yields exactly one trigger.
        channel[0] = 1'b1;
        pulse_width = 8'd2; dead_time = 8'd4;
        repeat (2) @(negedge clk);
        c0 = cyc;
        rst = 1'b0;
        push_exp(0, c0 + 3, 2, 4);
        repeat (20) @(negedge clk);
        channel[0] = 1'b0;
        repeat (5) @(negedge clk);
        exp_acc[0] = 1;
        check_counters("held_high");

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
